// File: rtl/memory_responder.sv
// memory_responder: word-addressed memory serving MAR/MDR accesses with a fixed programmable latency.
// Ports:
//   clk        in  clock, all state changes on the rising edge
//   clr        in  synchronous active-low reset
//   Read       in  read request, sampled only in IDLE
//   Write      in  write request, sampled only in IDLE
//   addr       in  [ADDR_W-1:0] word address from MAR
//   data_in    in  [DATA_W-1:0] write data from MDR
//   Mdatain    out [DATA_W-1:0] registered read data to MDR
//   mem_ready  out one-cycle completion pulse (DONE)
//   busy       out high in WAIT and DONE
//   err        out one-cycle pulse on a rejected request
// Optional feature: define MEM_WRITE_PROTECT_EN to make addresses 0..PROTECT_TOP read-only.
module memory_responder #(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 32,
    parameter int                LATENCY     = 2,
    parameter logic [ADDR_W-1:0] PROTECT_TOP = 9'h03F
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_ready,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;
    logic                err_q, err_d;
    logic                commit, prot, mem_we;
    logic [DATA_W-1:0]   mem [2**ADDR_W];

    assign commit = (state_q == WAIT) && (cnt_q == 4'd0);
`ifdef MEM_WRITE_PROTECT_EN
    assign prot = wr_q && (addr_q <= PROTECT_TOP);
`else
    // Protection disabled: the term is constant zero, PROTECT_TOP only kept referenced.
    assign prot = 1'b0 & (addr_q <= PROTECT_TOP);
`endif
    // Gating with clr gives reset priority over a commit on the same edge.
    assign mem_we = clr && commit && wr_q && !prot;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mdr_d   = mdr_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Read ^ Write) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY - 1);
                    wr_d    = Write;
                    addr_d  = addr;
                    data_d  = data_in;
                end else begin
                    err_d = Read & Write;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    mdr_d   = wr_q ? mdr_q : mem[addr_q];
                    err_d   = prot;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[addr_q] <= data_q;
    end

    assign Mdatain   = mdr_q;
    assign mem_ready = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: randomized self-checking bench for memory_responder against a behavioural memory model.
module tb_memory_responder;
    localparam int LAT = 2;
    localparam logic [8:0] PTOP = 9'h03F;

    logic        clk = 1'b0;
    logic        clr, Read, Write;
    logic [8:0]  addr;
    logic [31:0] data_in, Mdatain;
    logic        mem_ready, busy, err;

    logic [31:0] mem_m [512];
    bit          known [512];
    logic [31:0] exp_mdr;
    bit          mdr_known;
    int          checks = 0;
    int          errors = 0;

    memory_responder #(.ADDR_W(9), .DATA_W(32), .LATENCY(LAT), .PROTECT_TOP(PTOP)) dut (
        .clk(clk), .clr(clr), .Read(Read), .Write(Write), .addr(addr), .data_in(data_in),
        .Mdatain(Mdatain), .mem_ready(mem_ready), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_prot(input logic wr, input logic [8:0] a);
`ifdef MEM_WRITE_PROTECT_EN
        return wr && (a <= PTOP);
`else
        return 1'b0 && wr && (a <= PTOP);
`endif
    endfunction

    task automatic idle_check();
        check("idle_busy", 32'(busy), 0);
        check("idle_rdy", 32'(mem_ready), 0);
        check("idle_err", 32'(err), 0);
        if (mdr_known) check("idle_mdr", Mdatain, exp_mdr);
    endtask

    // One request issued at the first idle negedge; with inj a stray Read to 1FF is pulsed while busy.
    task automatic op(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d, input bit inj);
        bit p;
        p = is_prot(wr, a);
        @(negedge clk);
        idle_check();
        Read = rd; Write = wr; addr = a; data_in = d;
        @(posedge clk);
        #1 Read = 1'b0; Write = 1'b0;
        if (rd && wr) begin
            @(negedge clk);
            check("conf_err", 32'(err), 1);
            check("conf_busy", 32'(busy), 0);
            check("conf_rdy", 32'(mem_ready), 0);
        end else begin
            for (int c = 0; c <= LAT; c++) begin
                @(negedge clk);
                if (c == LAT) begin
                    if (rd) begin exp_mdr = mem_m[a]; mdr_known = known[a]; end
                    if (wr && !p) begin mem_m[a] = d; known[a] = 1'b1; end
                end
                check("op_busy", 32'(busy), 1);
                check("op_rdy", 32'(mem_ready), 32'(c == LAT));
                check("op_err", 32'(err), 32'(p && c == LAT));
                if (mdr_known) check("op_mdr", Mdatain, exp_mdr);
                if (inj && c == 0) begin Read = 1'b1; addr = 9'h1FF; end
                if (inj && c == 1) Read = 1'b0;
            end
        end
    endtask

    // Write to a, then drop clr in WAIT cycle c (c = LAT-1 puts the reset on the commit edge).
    task automatic reset_mid(input logic [8:0] a, input logic [31:0] d, input int c);
        @(negedge clk);
        idle_check();
        Write = 1'b1; addr = a; data_in = d;
        @(posedge clk);
        #1 Write = 1'b0;
        for (int i = 0; i <= c; i++) begin
            @(negedge clk);
            check("rst_busy", 32'(busy), 1);
        end
        clr = 1'b0;
        @(negedge clk);
        check("rst_busy0", 32'(busy), 0);
        check("rst_mdr0", Mdatain, 0);
        check("rst_rdy0", 32'(mem_ready), 0);
        exp_mdr = 32'h0; mdr_known = 1'b1;
        clr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_norody", 32'(mem_ready), 0);
            check("rst_idle", 32'(busy), 0);
        end
    endtask

    initial begin
        clr = 1'b0; Read = 1'b0; Write = 1'b0; addr = '0; data_in = '0;
        exp_mdr = '0; mdr_known = 1'b1;
        for (int i = 0; i < 512; i++) begin mem_m[i] = '0; known[i] = 1'b0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle_check();
        end
        for (int i = 0; i < 512; i++) op(1'b0, 1'b1, 9'(i), (i == 'h101) ? 32'h0 : $urandom, 1'b0);
        op(1'b0, 1'b1, 9'h100, 32'hDEADBEEF, 1'b0);
        op(1'b1, 1'b0, 9'h100, 32'h0, 1'b0);
        check("dir_rd100", Mdatain, 32'hDEADBEEF);
        op(1'b1, 1'b1, 9'h100, 32'h0BADF00D, 1'b0);
        op(1'b1, 1'b0, 9'h100, 32'h0, 1'b0);
        check("conf_rd100", Mdatain, 32'hDEADBEEF);
        reset_mid(9'h101, 32'h12345678, 0);
        reset_mid(9'h101, 32'h12345678, LAT - 1);
        op(1'b1, 1'b0, 9'h101, 32'h0, 1'b0);
        check("abort_rd101", Mdatain, 32'h0);
        op(1'b1, 1'b0, 9'h100, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_check();
        end
`ifdef MEM_WRITE_PROTECT_EN
        op(1'b0, 1'b1, 9'h010, 32'hAAAA5555, 1'b0);
        op(1'b1, 1'b0, 9'h010, 32'h0, 1'b0);
        op(1'b0, 1'b1, 9'h040, 32'hAAAA5555, 1'b0);
        op(1'b1, 1'b0, 9'h040, 32'h0, 1'b0);
        check("prot_rd040", Mdatain, 32'hAAAA5555);
`endif
        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 9);
            op(k >= 5 || k == 0, k < 5, 9'($urandom), $urandom, 1'b0);
        end
        @(negedge clk);
        idle_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
